// File: rtl/led_display_pkg.sv
// Shared LED display definitions: command bytes, width helpers, readback FSM states.
// LINE_READBACK_CHECKSUM_EN adds the CSUM state.
package led_display_pkg;

   localparam logic [7:0] CMD_LINE = 8'h4C;

   function automatic int row_w(input int height);
      return $clog2(height);
   endfunction

   function automatic int col_w(input int line_bytes);
      return $clog2(line_bytes);
   endfunction

   function automatic int addr_w(input int height, input int line_bytes);
      return $clog2(height * line_bytes);
   endfunction

`ifdef LINE_READBACK_CHECKSUM_EN
   typedef enum logic [2:0] {
      ST_IDLE, ST_HDR_CMD, ST_HDR_ROW, ST_DATA, ST_CSUM, ST_FIN
   } line_readback_state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE, ST_HDR_CMD, ST_HDR_ROW, ST_DATA, ST_FIN
   } line_readback_state_t;
`endif

endpackage

// File: rtl/line_readback_tx_uart_tx.sv
// 8N1 UART transmitter; ready rises on the last stop-bit tick so a load
// in that cycle chains the next start bit with no idle gap.
module uart_tx #(
   parameter int TICKS_PER_BIT = 9
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] data,
   output logic       tx,
   output logic       ready
);

   localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;

   logic          active_q;
   logic [3:0]    bit_q;
   logic [TW-1:0] tick_q;
   logic [8:0]    shift_q;
   logic          tx_q;
   logic          last_tick;

   assign last_tick = (tick_q == TW'(TICKS_PER_BIT - 1));
   assign ready     = !active_q || (bit_q == 4'd9 && last_tick);
   assign tx        = tx_q;

   // shift_q carries data bits then the stop bit, shifted out LSB first
   always_ff @(posedge clk_in) begin
      if (reset) begin
         active_q <= 1'b0;
         bit_q    <= '0;
         tick_q   <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
      end else if (load && ready) begin
         active_q <= 1'b1;
         bit_q    <= '0;
         tick_q   <= '0;
         shift_q  <= {1'b1, data};
         tx_q     <= 1'b0;
      end else if (active_q) begin
         if (last_tick) begin
            tick_q <= '0;
            if (bit_q == 4'd9) begin
               active_q <= 1'b0;
            end else begin
               bit_q   <= bit_q + 4'd1;
               tx_q    <= shift_q[0];
               shift_q <= {1'b1, shift_q[8:1]};
            end
         end else begin
            tick_q <= tick_q + TW'(1);
         end
      end
   end

endmodule

// File: rtl/line_readback_tx.sv
// Reads one framebuffer row from display RAM and sends it as an "L" line frame.
// Define LINE_READBACK_CHECKSUM_EN to append an XOR checksum byte.
module line_readback_tx
   import led_display_pkg::*;
#(
   parameter int UART_CLK_TICKS_PER_BIT = 9,
   parameter int PIXEL_WIDTH            = 64,
   parameter int PIXEL_HEIGHT           = 32,
   parameter int BYTES_PER_PIXEL        = 2
) (
   input  logic                                  clk_in,
   input  logic                                  reset,
   input  logic                                  start,
   input  logic [row_w(PIXEL_HEIGHT)-1:0]        row,
   output logic                                  busy,
   output logic                                  done,
   output logic [addr_w(PIXEL_HEIGHT,
                        PIXEL_WIDTH*BYTES_PER_PIXEL)-1:0] ram_address,
   output logic                                  ram_read_enable,
   input  logic [7:0]                            ram_data_in,
   output logic                                  uart_tx
);

   localparam int LINE_BYTES = PIXEL_WIDTH * BYTES_PER_PIXEL;
   localparam int RW         = row_w(PIXEL_HEIGHT);
   localparam int CW         = col_w(LINE_BYTES);
   localparam int AW         = addr_w(PIXEL_HEIGHT, LINE_BYTES);

   line_readback_state_t state_q, state_d;

   logic [RW-1:0] row_q;
   logic [CW-1:0] col_q, col_d;
   logic          last_q, last_d;
   logic [7:0]    hold_q;
   logic          rd_pend_q;
   logic          accept;
   logic          rd_fire;
   logic          tx_load;
   logic [7:0]    tx_data;
   logic          tx_ready;
`ifdef LINE_READBACK_CHECKSUM_EN
   logic [7:0]    csum_q, csum_d;
`endif

   uart_tx #(
      .TICKS_PER_BIT(UART_CLK_TICKS_PER_BIT)
   ) u_uart_tx (
      .clk_in(clk_in),
      .reset (reset),
      .load  (tx_load),
      .data  (tx_data),
      .tx    (uart_tx),
      .ready (tx_ready)
   );

   // col_q holds the column of the most recent read; last_q marks the
   // final data byte already sitting in the shifter
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      last_d  = last_q;
      accept  = 1'b0;
      rd_fire = 1'b0;
      tx_load = 1'b0;
      tx_data = hold_q;
`ifdef LINE_READBACK_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               accept  = 1'b1;
               tx_load = 1'b1;
               tx_data = CMD_LINE;
               col_d   = CW'(LINE_BYTES - 1);
               last_d  = 1'b0;
`ifdef LINE_READBACK_CHECKSUM_EN
               csum_d  = '0;
`endif
               state_d = ST_HDR_CMD;
            end
         end
         ST_HDR_CMD: begin
            if (tx_ready) begin
               tx_load = 1'b1;
               tx_data = 8'(row_q);
               rd_fire = 1'b1;
               state_d = ST_HDR_ROW;
            end
         end
         ST_HDR_ROW: begin
            if (tx_ready) begin
               tx_load = 1'b1;
               rd_fire = 1'b1;
               col_d   = col_q - 1'b1;
`ifdef LINE_READBACK_CHECKSUM_EN
               csum_d  = csum_q ^ hold_q;
`endif
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (tx_ready) begin
               if (last_q) begin
`ifdef LINE_READBACK_CHECKSUM_EN
                  tx_load = 1'b1;
                  tx_data = csum_q;
                  state_d = ST_CSUM;
`else
                  state_d = ST_FIN;
`endif
               end else begin
                  tx_load = 1'b1;
`ifdef LINE_READBACK_CHECKSUM_EN
                  csum_d  = csum_q ^ hold_q;
`endif
                  if (col_q == '0) begin
                     last_d = 1'b1;
                  end else begin
                     col_d   = col_q - 1'b1;
                     rd_fire = 1'b1;
                  end
               end
            end
         end
`ifdef LINE_READBACK_CHECKSUM_EN
         ST_CSUM: begin
            if (tx_ready) state_d = ST_FIN;
         end
`endif
         ST_FIN: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy            = (state_q != ST_IDLE) && (state_q != ST_FIN);
   assign done            = (state_q == ST_FIN);
   assign ram_read_enable = rd_fire;
   assign ram_address     = rd_fire ? AW'({row_q, ~col_d}) : '0;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         row_q     <= '0;
         col_q     <= '0;
         last_q    <= 1'b0;
         hold_q    <= '0;
         rd_pend_q <= 1'b0;
`ifdef LINE_READBACK_CHECKSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         last_q    <= last_d;
         rd_pend_q <= rd_fire;
         if (accept) row_q <= row;
         if (rd_pend_q) hold_q <= ram_data_in;
`ifdef LINE_READBACK_CHECKSUM_EN
         csum_q    <= csum_d;
`endif
      end
   end

endmodule

// File: tb/tb_line_readback_tx.sv
// Bench for line_readback_tx: cycle-exact expected waveform built from the frame byte list.
module tb_line_readback_tx;

   localparam int LB  = 128;
   localparam int TPB = 9;
   localparam int BYTE_CYC = 10 * TPB;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [4:0]  row;
   logic        busy;
   logic        done;
   logic [11:0] ram_address;
   logic        ram_read_enable;
   logic [7:0]  ram_data;
   logic        uart_tx;

   logic [7:0]  mem [4096];

   int passed = 0;
   int total  = 0;

   line_readback_tx dut (
      .clk_in         (clk),
      .reset          (reset),
      .start          (start),
      .row            (row),
      .busy           (busy),
      .done           (done),
      .ram_address    (ram_address),
      .ram_read_enable(ram_read_enable),
      .ram_data_in    (ram_data),
      .uart_tx        (uart_tx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_read_enable) ram_data <= mem[ram_address];
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Runs one frame from the next IDLE cycle; abort_at>=0 fires reset then.
   task automatic run_frame(input string tag, input logic [4:0] r,
                            input int abort_at, input int poke_a,
                            input int poke_b);
      logic [7:0] q[$];
      logic [7:0] x;
      logic [7:0] cur;
      logic       eb;
      int fl, b, j;
      int wave_err, first_bad, busy_err, done_err, addr_err, nrd, idle_err;
      bit aborted;
      x = 8'h00;
      wave_err = 0; first_bad = -1; busy_err = 0; done_err = 0;
      addr_err = 0; nrd = 0; idle_err = 0; aborted = 1'b0;
      q.push_back(8'h4C);
      q.push_back({3'b000, r});
      for (int i = 0; i < LB; i++) begin
         q.push_back(mem[int'(r) * LB + i]);
         x ^= mem[int'(r) * LB + i];
      end
`ifdef LINE_READBACK_CHECKSUM_EN
      q.push_back(x);
`endif
      fl = q.size() * BYTE_CYC;
      @(negedge clk);
      row   = r;
      start = 1'b1;
      @(posedge clk);
      for (int k = 0; k <= fl; k++) begin
         @(negedge clk);
         if (k == fl) begin
            check({tag, " done at end"}, done, 1);
            check({tag, " busy at done"}, busy, 0);
         end else begin
            b   = k / BYTE_CYC;
            j   = (k % BYTE_CYC) / TPB;
            cur = q[b];
            eb  = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : cur[j-1];
            if (uart_tx !== eb) begin
               if (wave_err == 0) first_bad = k;
               wave_err++;
            end
            if (busy !== 1'b1) busy_err++;
            if (done !== 1'b0) done_err++;
         end
         if (ram_read_enable === 1'b1) begin
            if (ram_address !== 12'(int'(r) * LB + nrd)) addr_err++;
            nrd++;
         end
         start = (k == poke_a || k == poke_b || k == fl);
         if (k == abort_at) begin
            reset   = 1'b1;
            start   = 1'b0;
            aborted = 1'b1;
            break;
         end
      end
      if (aborted) begin
         @(negedge clk);
         check({tag, " tx after reset"}, uart_tx, 1);
         check({tag, " busy after reset"}, busy, 0);
         check({tag, " wave before reset"}, wave_err, 0);
         reset = 1'b0;
         for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || uart_tx !== 1'b1 || busy !== 1'b0)
               idle_err++;
         end
         check({tag, " quiet after abort"}, idle_err, 0);
      end else begin
         check({tag, " waveform errs"}, wave_err, 0);
         if (wave_err != 0)
            $display("%s first waveform deviation at cycle %0d", tag, first_bad);
         check({tag, " busy in frame"}, busy_err, 0);
         check({tag, " early done"}, done_err, 0);
         check({tag, " read count"}, nrd, LB);
         check({tag, " read addrs"}, addr_err, 0);
      end
   endtask

   initial begin
      logic [4:0] r;
      int idle_err;
      reset = 1'b1;
      start = 1'b0;
      row   = '0;
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
      repeat (3) @(negedge clk);
      check("rst uart_tx", uart_tx, 1);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst read_en", ram_read_enable, 0);
      check("rst address", ram_address, 0);
      reset = 1'b0;

      for (int i = 0; i < LB; i++) mem[5 * LB + i] = 8'(i);
      run_frame("f1 row5", 5'd5, -1, -1, -1);

      r = 5'($urandom_range(0, 31));
      run_frame("f2 pokes", r, -1, 1, 5000);

      r = 5'($urandom_range(0, 30));
      run_frame("f3 abort", r, 300, -1, -1);

      run_frame("f3 row31", 5'd31, -1, -1, -1);

      r = 5'($urandom_range(0, 31));
      for (int i = 0; i < LB; i++) mem[int'(r) * LB + i] = 8'hA5;
      run_frame("f4 a5", r, -1, -1, -1);

      for (int i = 0; i < LB; i++) mem[int'(r) * LB + i] = 8'h00;
      mem[int'(r) * LB] = 8'h01;
      run_frame("f4 one", r, -1, -1, -1);

      @(negedge clk);
      start = 1'b0;
      idle_err = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy !== 1'b0 || uart_tx !== 1'b1) idle_err++;
      end
      check("idle after last", idle_err, 0);

      start = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      check("rst+start busy", busy, 0);
      check("rst+start tx", uart_tx, 1);
      start = 1'b0;
      reset = 1'b0;
      idle_err = 0;
      repeat (50) begin
         @(negedge clk);
         if (busy !== 1'b0 || uart_tx !== 1'b1 || done !== 1'b0) idle_err++;
      end
      check("rst+start quiet", idle_err, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
